// File: rtl/spi_master_cmd_pkg.sv
// Shared opcodes, frame geometry and FSM encoding for the SPI command master and slave.
// Also holds the frame builder so the frame layout is defined in one place.
package spi_master_cmd_pkg;

    localparam int FRAME_BITS   = 40;
    localparam int PAYLOAD_BITS = 32;

    localparam logic [7:0] OP_START = 8'h01;
    localparam logic [7:0] OP_STOP  = 8'h02;
    localparam logic [7:0] OP_TON   = 8'h10;
    localparam logic [7:0] OP_TOFF  = 8'h11;
    localparam logic [7:0] OP_IP    = 8'h12;
    localparam logic [7:0] OP_WAVE  = 8'h13;
    localparam logic [7:0] OP_RD_FB = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Commands that carry no payload send zeros; everything else (including unknown opcodes) sends cmd_data.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] code, input logic [15:0] data);
        logic [PAYLOAD_BITS-1:0] payload;
        if (code == OP_START || code == OP_STOP || code == OP_RD_FB)
            payload = '0;
        else
            payload = {16'h0000, data};
        return {code, payload};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// sclk half-period divider: one-cycle rise/fall enables every CLK_DIV cycles, low phase first.
// Latency: first rise_tick CLK_DIV cycles after en rises; no backpressure, held cleared while en is low.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          phase;
    logic          term;

    assign term      = en && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = term && !phase;
    assign fall_tick = term && phase;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (term) begin
            cnt   <= '0;
            phase <= !phase;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_cmd.sv
// SPI mode-0 command master: one 40-bit frame per accepted command, 32-bit feedback returned for RD_FB.
// Latency: accept to cs_n rise 1+CS_SETUP+80*CLK_DIV+CS_HOLD cycles; cmd_ready only in IDLE, requests held off while busy.
module spi_master_cmd
    import spi_master_cmd_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int IDLE_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    state_t                  state;
    state_t                  state_nxt;
    logic [15:0]             wait_cnt;
    logic [5:0]              bit_cnt;
    logic [FRAME_BITS-1:0]   tx_sr;
    logic [PAYLOAD_BITS-1:0] rx_sr;
    logic                    miso_s1;
    logic                    miso_s2;
    logic                    is_rd;
    logic                    rise_tick;
    logic                    fall_tick;
    logic                    accept;
    logic                    last_bit;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (state == ST_SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign last_bit  = fall_tick && (bit_cnt == 6'(FRAME_BITS - 1));
    assign busy      = (state != ST_IDLE);
    assign cs_n      = !(state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD);
    assign mosi      = tx_sr[FRAME_BITS-1];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SETUP;
            ST_SETUP: if (wait_cnt == 16'(CS_SETUP - 1)) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_HOLD;
            ST_HOLD:  if (wait_cnt == 16'(CS_HOLD - 1)) state_nxt = ST_GAP;
            ST_GAP:   if (wait_cnt == 16'(IDLE_GAP - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            miso_s1   <= 1'b0;
            miso_s2   <= 1'b0;
            is_rd     <= 1'b0;
            sclk      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state   <= state_nxt;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;

            // Per-state dwell counter restarts on every state change.
            if (state_nxt != state || state == ST_IDLE)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 16'd1;

            if (state != ST_SHIFT)
                bit_cnt <= '0;
            else if (fall_tick)
                bit_cnt <= bit_cnt + 6'd1;

            if (rise_tick)
                sclk <= 1'b1;
            else if (fall_tick)
                sclk <= 1'b0;

            // Sampling at the end of the high phase also shifts the opcode bits through rx_sr;
            // only the final 32 samples (the payload) survive.
            if (accept) begin
                tx_sr <= build_frame(cmd_code, cmd_data);
                is_rd <= (cmd_code == OP_RD_FB);
            end else if (fall_tick) begin
                tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                rx_sr <= {rx_sr[PAYLOAD_BITS-2:0], miso_s2};
            end

            rsp_valid <= 1'b0;
            if (state == ST_HOLD && state_nxt == ST_GAP && is_rd) begin
                rsp_valid <= 1'b1;
                rsp_data  <= rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cmd.sv
// Bench for spi_master_cmd: three instances (CLK_DIV 4, 3, 7) driven through command scenarios,
// with a bit-level SPI slave model and frame decoder computing expected results from the frame rules.
module tb_spi_master_cmd;

    localparam int NI       = 3;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int IDLE_GAP = 8;

    typedef struct {
        logic [39:0] frame;
        int          low_cycles;
        int          rises;
        bit          phase_ok;
        bit          stable_ok;
        int          rsp_cnt;
        logic [31:0] rsp_last;
        bit          ready_ok;
        int          gap;
        bit          timeout;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid [NI];
    logic        cmd_ready [NI];
    logic [7:0]  cmd_code  [NI];
    logic [15:0] cmd_data  [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_data  [NI];
    logic        busy      [NI];
    logic        sclk      [NI];
    logic        mosi      [NI];
    logic        miso      [NI];
    logic        cs_n      [NI];

    logic [7:0]  wr_ops [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_master_cmd #(
            .CLK_DIV  ((g == 0) ? 4 : ((g == 1) ? 3 : 7)),
            .CS_SETUP (CS_SETUP),
            .CS_HOLD  (CS_HOLD),
            .IDLE_GAP (IDLE_GAP)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_code  (cmd_code[g]),
            .cmd_data  (cmd_data[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_data  (rsp_data[g]),
            .busy      (busy[g]),
            .sclk      (sclk[g]),
            .mosi      (mosi[g]),
            .miso      (miso[g]),
            .cs_n      (cs_n[g])
        );
    end

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 3 : 7);
    endfunction

    function automatic int exp_low(input int div);
        return CS_SETUP + 2 * 40 * div + CS_HOLD;
    endfunction

    function automatic logic [39:0] exp_frame(input logic [7:0] code, input logic [15:0] data);
        if (code == 8'h01 || code == 8'h02 || code == 8'h20)
            return {code, 32'h0};
        return {code, 16'h0000, data};
    endfunction

    // Called on a negedge; returns on the negedge whose following posedge accepts the command.
    task automatic send(input int k, input logic [7:0] code, input logic [15:0] data, output bit ok);
        cmd_code[k]  = code;
        cmd_data[k]  = data;
        cmd_valid[k] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (cmd_ready[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Plays the SPI slave (returns {8'h00, fb}) and decodes the frame until the DUT is ready again.
    task automatic observe(input int k, input logic [31:0] fb, input bit keep,
                           input logic [7:0] next_code, output obs_t o);
        logic [39:0] resp;
        int bi, run, div;
        logic ps, pm;
        bit done;
        resp = {8'h00, fb};
        div  = div_of(k);
        o.frame = '0; o.low_cycles = 0; o.rises = 0; o.phase_ok = 1; o.stable_ok = 1;
        o.rsp_cnt = 0; o.rsp_last = '0; o.ready_ok = 1; o.gap = 0; o.timeout = 0;
        bi = 0; run = 0; ps = 1'b0; pm = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                if (keep) cmd_code[k] = next_code;
                else      cmd_valid[k] = 1'b0;
            end
            if (rsp_valid[k]) begin
                o.rsp_cnt++;
                o.rsp_last = rsp_data[k];
            end
            if (!cs_n[k]) begin
                o.low_cycles++;
                if (cmd_ready[k]) o.ready_ok = 0;
                if (sclk[k] !== ps) begin
                    if (ps) begin
                        if (run != div) o.phase_ok = 0;
                        bi++;
                    end else begin
                        o.rises++;
                        o.frame = {o.frame[38:0], mosi[k]};
                        if (mosi[k] !== pm) o.stable_ok = 0;
                        if (o.rises > 1 && run != div) o.phase_ok = 0;
                    end
                    run = 1;
                end else begin
                    run++;
                end
                miso[k] = (bi < 40) ? resp[39 - bi] : 1'b0;
                ps = sclk[k];
                pm = mosi[k];
            end else if (o.low_cycles > 0) begin
                o.gap++;
                miso[k] = 1'b0;
                if (cmd_ready[k]) done = 1'b1;
            end
        end
        o.timeout = !done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({cs_n[k], sclk[k], mosi[k], cmd_ready[k], rsp_valid[k], busy[k]} !== 6'b100000
                || rsp_data[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: cs_n,sclk,mosi,ready,rsp_valid,busy=%b rsp_data=%h, want 100000 and 0",
                         k, {cs_n[k], sclk[k], mosi[k], cmd_ready[k], rsp_valid[k], busy[k]}, rsp_data[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (cmd_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_after_reset dut%0d: ready=%b busy=%b, want 1 0", k, cmd_ready[k], busy[k]);
            end
        end
    endtask

    task automatic test_write();
        obs_t o;
        bit ok;
        logic [7:0] code;
        logic [15:0] data;
        for (int i = 0; i < 3; i++) begin
            code = (i == 0) ? 8'h10 : wr_ops[$urandom_range(0, 3)];
            data = (i == 0) ? 16'h1234 : 16'($urandom);
            send(0, code, data, ok);
            observe(0, 32'h0, 1'b0, 8'h00, o);
            n_checks++;
            if (!ok || o.timeout || o.frame !== exp_frame(code, data)) begin
                n_fail++;
                $display("FAIL write_frame op=%h: got %h, want %h (accepted=%0d timeout=%0d)",
                         code, o.frame, exp_frame(code, data), ok, o.timeout);
            end
            n_checks++;
            if (o.low_cycles != exp_low(4) || o.rsp_cnt != 0) begin
                n_fail++;
                $display("FAIL write_timing: cs_n low %0d cycles, rsp pulses %0d; want %0d and 0",
                         o.low_cycles, o.rsp_cnt, exp_low(4));
            end
        end
        n_checks++;
        if (exp_frame(8'h10, 16'h1234) !== o.frame && code == 8'h10 && data == 16'h1234) begin
            n_fail++;
            $display("FAIL ton_literal: got %h, want 1000001234", o.frame);
        end
    endtask

    task automatic test_rd_fb();
        obs_t o;
        bit ok;
        logic [31:0] fb;
        for (int i = 0; i < 3; i++) begin
            fb = (i == 0) ? 32'h0F0F0F0F : $urandom;
            send(0, 8'h20, 16'($urandom), ok);
            observe(0, fb, 1'b0, 8'h00, o);
            n_checks++;
            if (!ok || o.timeout || o.rsp_cnt != 1 || o.rsp_last !== fb) begin
                n_fail++;
                $display("FAIL rd_fb_rsp: pulses %0d data %h, want 1 pulse data %h", o.rsp_cnt, o.rsp_last, fb);
            end
            n_checks++;
            if (o.frame !== 40'h20_0000_0000) begin
                n_fail++;
                $display("FAIL rd_fb_frame: got %h, want 2000000000", o.frame);
            end
        end
        send(0, 8'h13, 16'($urandom), ok);
        observe(0, 32'hFFFF_FFFF, 1'b0, 8'h00, o);
        n_checks++;
        if (rsp_data[0] !== fb || o.rsp_cnt != 0) begin
            n_fail++;
            $display("FAIL rsp_hold: rsp_data %h pulses %0d after write, want %h and 0", rsp_data[0], o.rsp_cnt, fb);
        end
    endtask

    task automatic test_clk_div_sweep();
        obs_t o;
        bit ok;
        logic [7:0] code;
        logic [15:0] data;
        logic [31:0] fb;
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 2; j++) begin
                code = (j == 0) ? wr_ops[$urandom_range(0, 3)] : 8'h20;
                data = 16'($urandom);
                fb   = $urandom;
                send(k, code, data, ok);
                observe(k, fb, 1'b0, 8'h00, o);
                n_checks++;
                if (!ok || o.timeout || o.rises != 40 || !o.phase_ok || !o.stable_ok) begin
                    n_fail++;
                    $display("FAIL sweep_sclk div=%0d: rises %0d phase_ok %0d stable_ok %0d timeout %0d, want 40 1 1 0",
                             div_of(k), o.rises, o.phase_ok, o.stable_ok, o.timeout);
                end
                n_checks++;
                if (o.frame !== exp_frame(code, data) || o.low_cycles != exp_low(div_of(k))) begin
                    n_fail++;
                    $display("FAIL sweep_frame div=%0d: frame %h low %0d, want %h low %0d",
                             div_of(k), o.frame, o.low_cycles, exp_frame(code, data), exp_low(div_of(k)));
                end
                n_checks++;
                if (o.rsp_cnt != ((code == 8'h20) ? 1 : 0) || (code == 8'h20 && o.rsp_last !== fb)) begin
                    n_fail++;
                    $display("FAIL sweep_rsp div=%0d op=%h: pulses %0d data %h, want fb %h",
                             div_of(k), code, o.rsp_cnt, o.rsp_last, fb);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        bit ok;
        send(1, 8'h01, 16'($urandom), ok);
        observe(1, 32'h0, 1'b1, 8'h02, o1);
        observe(1, 32'h0, 1'b0, 8'h00, o2);
        n_checks++;
        if (!ok || o1.timeout || o2.timeout || o1.frame !== 40'h01_0000_0000 || o2.frame !== 40'h02_0000_0000) begin
            n_fail++;
            $display("FAIL b2b_frames: got %h then %h, want 0100000000 then 0200000000", o1.frame, o2.frame);
        end
        n_checks++;
        if (o1.gap < IDLE_GAP + 1) begin
            n_fail++;
            $display("FAIL b2b_gap: cs_n high %0d cycles between frames, want >= %0d", o1.gap, IDLE_GAP + 1);
        end
        n_checks++;
        if (!o1.ready_ok || !o2.ready_ok || o1.rsp_cnt != 0 || o2.rsp_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b_ready: ready_low %0d/%0d rsp %0d/%0d, want 1/1 0/0",
                     o1.ready_ok, o2.ready_ok, o1.rsp_cnt, o2.rsp_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        bit ok, hit;
        int rises, pulses;
        logic prev;
        logic [15:0] data;
        send(0, 8'h20, 16'h0, ok);
        rises = 0; prev = 1'b0; hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid[0] = 1'b0;
            miso[0] = 1'($urandom);
            if (sclk[0] && !prev) rises++;
            prev = sclk[0];
            if (rises == 20) hit = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (!ok || !hit || cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: reached=%0d cs_n=%b sclk=%b busy=%b rsp_valid=%b, want 1 1 0 0 0",
                     hit, cs_n[0], sclk[0], busy[0], rsp_valid[0]);
        end
        miso[0] = 1'b0;
        rst = 1'b0;
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (rsp_valid[0]) pulses++;
        end
        n_checks++;
        if (pulses != 0 || rsp_data[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_rsp: %0d pulses rsp_data %h, want 0 and 0", pulses, rsp_data[0]);
        end
        data = 16'($urandom);
        send(0, 8'h11, data, ok);
        observe(0, 32'h0, 1'b0, 8'h00, o);
        n_checks++;
        if (!ok || o.timeout || o.frame !== {8'h11, 16'h0000, data} || o.low_cycles != exp_low(4) || o.rsp_cnt != 0) begin
            n_fail++;
            $display("FAIL post_reset_toff: frame %h low %0d rsp %0d, want %h %0d 0",
                     o.frame, o.low_cycles, o.rsp_cnt, {8'h11, 16'h0000, data}, exp_low(4));
        end
    endtask

    task automatic test_unknown_opcode();
        obs_t o;
        bit ok;
        logic [15:0] data;
        data = 16'($urandom);
        send(2, 8'h7F, data, ok);
        observe(2, $urandom, 1'b0, 8'h00, o);
        n_checks++;
        if (!ok || o.timeout || o.frame !== {8'h7F, 16'h0000, data} || o.rsp_cnt != 0) begin
            n_fail++;
            $display("FAIL unknown_op: frame %h rsp %0d, want %h and 0", o.frame, o.rsp_cnt, {8'h7F, 16'h0000, data});
        end
        n_checks++;
        if (busy[2] !== 1'b0 || cmd_ready[2] !== 1'b1 || o.low_cycles != exp_low(7)) begin
            n_fail++;
            $display("FAIL unknown_op_idle: busy=%b ready=%b low=%0d, want 0 1 %0d",
                     busy[2], cmd_ready[2], o.low_cycles, exp_low(7));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            cmd_valid[k] = 1'b0;
            cmd_code[k]  = 8'h00;
            cmd_data[k]  = 16'h0000;
            miso[k]      = 1'b0;
        end
        test_reset();
        test_write();
        test_rd_fb();
        test_clk_div_sweep();
        test_back_to_back();
        test_reset_mid_frame();
        test_unknown_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
